// File: rtl/tdm_demux4.sv
// Receive side of the 4-slot TDM link: locks to the slot-0 frame marker, stages
// each slot's sample and publishes all four channels together once per frame.
module tdm_demux4 #(
  parameter int WIDTH       = 1,
  parameter int SLOT_CYCLES = 1,
  parameter int SAMPLE_POS  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             frame,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             valid,
  output logic             sel1,
  output logic             sel0,
  output logic             locked,
  output logic             sync_err
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST   = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_SAMPLE = CW'(SAMPLE_POS);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] stage_q [3];

  logic          at_marker, missing, unexpected, active, sample, publish;
  logic [1:0]    eff_slot;
  logic [CW-1:0] eff_cyc;

  // A frame marker always defines "now" as slot 0 / cycle 0, whether it is the
  // acquisition marker, the expected one, or a resync.
  always_comb begin
    at_marker  = (slot_q == 2'd0) && (cyc_q == '0);
    missing    = (state_q == LOCKED) && at_marker && !frame;
    unexpected = (state_q == LOCKED) && frame && !at_marker;
    active     = ((state_q == LOCKED) && !missing) || frame;
    eff_slot   = frame ? 2'd0 : slot_q;
    eff_cyc    = frame ? '0 : cyc_q;
    sample     = active && (eff_cyc == CYC_SAMPLE);
    publish    = sample && (eff_slot == 2'd3);

    state_d = HUNT;
    slot_d  = 2'd0;
    cyc_d   = '0;
    if (active) begin
      state_d = LOCKED;
      if (eff_cyc == CYC_LAST) begin
        cyc_d  = '0;
        slot_d = eff_slot + 2'd1;
      end else begin
        cyc_d  = eff_cyc + 1'b1;
        slot_d = eff_slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= 2'd0;
      cyc_q    <= '0;
      for (int i = 0; i < 3; i++) stage_q[i] <= '0;
      out0     <= '0;
      out1     <= '0;
      out2     <= '0;
      out3     <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cyc_q   <= cyc_d;
      // A framing violation throws away the partial frame before this cycle's sample.
      for (int i = 0; i < 3; i++) begin
        if (missing || unexpected) stage_q[i] <= '0;
        if (sample && (eff_slot == 2'(i))) stage_q[i] <= in;
      end
      if (publish) begin
        out0 <= stage_q[0];
        out1 <= stage_q[1];
        out2 <= stage_q[2];
        out3 <= in;
      end
      valid    <= publish;
      sync_err <= missing || unexpected;
    end
  end

  // The slot counter is held at zero in HUNT, so sel needs no extra gating.
  assign locked = (state_q == LOCKED);
  assign sel1   = slot_q[1];
  assign sel0   = slot_q[0];

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: two instances (1-bit single-cycle slots, 4-bit 3-cycle
// slots) checked against a frame-position model and a published-frame queue.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_a = 1'b0, in_a = 1'b0;
  logic       frame_b = 1'b0;
  logic [3:0] in_b = 4'd0;

  logic       out0_a, out1_a, out2_a, out3_a, valid_a, sel1_a, sel0_a, locked_a, sync_err_a;
  logic [3:0] out0_b, out1_b, out2_b, out3_b;
  logic       valid_b, sel1_b, sel0_b, locked_b, sync_err_b;

  int tests = 0;
  int fails = 0;

  // clock / reset
  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(1), .SLOT_CYCLES(1), .SAMPLE_POS(0)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .frame(frame_a),
    .out0(out0_a), .out1(out1_a), .out2(out2_a), .out3(out3_a),
    .valid(valid_a), .sel1(sel1_a), .sel0(sel0_a), .locked(locked_a), .sync_err(sync_err_a)
  );

  tdm_demux4 #(.WIDTH(4), .SLOT_CYCLES(3), .SAMPLE_POS(1)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .frame(frame_b),
    .out0(out0_b), .out1(out1_b), .out2(out2_b), .out3(out3_b),
    .valid(valid_b), .sel1(sel1_b), .sel0(sel0_b), .locked(locked_b), .sync_err(sync_err_b)
  );

  // reference model: t = cycles elapsed since the last accepted marker, modulo one frame
  int         nn [2] = '{1, 3};
  int         pp [2] = '{0, 1};
  int         t  [2];
  bit         lk [2];
  bit         ev [2];
  bit         es [2];
  logic [3:0] stg  [2][4];
  logic [3:0] outv [2][4];

  logic [15:0] exp_qa[$];
  logic [15:0] exp_qb[$];

  task automatic model(input int k, input logic r, input logic f, input logic [3:0] d);
    bit act;
    int s, c;
    ev[k] = 0;
    es[k] = 0;
    act   = 0;
    if (r) begin
      lk[k] = 0;
      t[k]  = 0;
      for (int i = 0; i < 4; i++) begin stg[k][i] = 4'd0; outv[k][i] = 4'd0; end
    end else begin
      if (!lk[k]) begin
        if (f) begin t[k] = 0; act = 1; end
      end else if (t[k] == 0 && !f) begin
        es[k] = 1;
        lk[k] = 0;
        for (int i = 0; i < 4; i++) stg[k][i] = 4'd0;
      end else begin
        if (f && t[k] != 0) begin
          es[k] = 1;
          t[k]  = 0;
          for (int i = 0; i < 4; i++) stg[k][i] = 4'd0;
        end
        act = 1;
      end
      if (act) begin
        s = t[k] / nn[k];
        c = t[k] % nn[k];
        if (c == pp[k]) begin
          if (s == 3) begin
            outv[k][0] = stg[k][0];
            outv[k][1] = stg[k][1];
            outv[k][2] = stg[k][2];
            outv[k][3] = d;
            ev[k] = 1;
            if (k == 0) exp_qa.push_back({d, stg[k][2], stg[k][1], stg[k][0]});
            else        exp_qb.push_back({d, stg[k][2], stg[k][1], stg[k][0]});
          end else begin
            stg[k][s] = d;
          end
        end
        t[k]  = (t[k] + 1) % (4 * nn[k]);
        lk[k] = 1;
      end
    end
  endtask

  task automatic check(input int k);
    logic [4:0]  exp_st, got_st;
    logic [15:0] exp_o, got_o;
    logic [1:0]  sel;
    sel    = lk[k] ? 2'(t[k] / nn[k]) : 2'd0;
    exp_st = {ev[k], es[k], lk[k], sel};
    exp_o  = {outv[k][3], outv[k][2], outv[k][1], outv[k][0]};
    if (k == 0) begin
      got_st = {valid_a, sync_err_a, locked_a, sel1_a, sel0_a};
      got_o  = {3'd0, out3_a, 3'd0, out2_a, 3'd0, out1_a, 3'd0, out0_a};
    end else begin
      got_st = {valid_b, sync_err_b, locked_b, sel1_b, sel0_b};
      got_o  = {out3_b, out2_b, out1_b, out0_b};
    end
    tests++;
    if (got_st !== exp_st) begin
      fails++;
      $display("FAIL status dut%0d @%0t: {valid,sync_err,locked,sel} got %b expected %b", k, $time, got_st, exp_st);
    end
    tests++;
    if (got_o !== exp_o) begin
      fails++;
      $display("FAIL outs dut%0d @%0t: got %h expected %h", k, $time, got_o, exp_o);
    end
  endtask

  // driver: apply inputs, step the model on the edge, check away from the edge
  task automatic tick(input logic r, input logic fa, input logic ia, input logic fb, input logic [3:0] ib);
    rst = r; frame_a = fa; in_a = ia; frame_b = fb; in_b = ib;
    @(posedge clk);
    model(0, r, fa, {3'd0, ia});
    model(1, r, fb, ib);
    @(negedge clk);
    check(0);
    check(1);
  endtask

  // one frame on dut_a: bits[i] is slot i's data, fr[i] raises frame in slot i
  task automatic a_frame(input logic [3:0] bits, input logic [3:0] fr);
    for (int i = 0; i < 4; i++) tick(1'b0, fr[i], bits[i], 1'b0, 4'd0);
  endtask

  // one frame on dut_b; reset is asserted at cycle 0 of slot rst_slot (4 = never)
  task automatic b_frame(input logic [15:0] vals, input int rst_slot);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 3; c++) begin
        if (s == rst_slot && c == 0) begin
          tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
          return;
        end
        tick(1'b0, 1'b0, 1'b0, (s == 0 && c == 0), vals[4*s +: 4]);
      end
  endtask

  // scoreboard monitor: every published frame must match the oldest expected one
  always @(negedge clk) begin
    logic [15:0] e;
    if (valid_a) begin
      tests++;
      if (exp_qa.size() == 0) begin
        fails++;
        $display("FAIL frame dut0 @%0t: unexpected valid, outs %b%b%b%b", $time, out3_a, out2_a, out1_a, out0_a);
      end else begin
        e = exp_qa.pop_front();
        if ({3'd0, out3_a, 3'd0, out2_a, 3'd0, out1_a, 3'd0, out0_a} !== e) begin
          fails++;
          $display("FAIL frame dut0 @%0t: got %b%b%b%b expected %h", $time, out3_a, out2_a, out1_a, out0_a, e);
        end
      end
    end
    if (valid_b) begin
      tests++;
      if (exp_qb.size() == 0) begin
        fails++;
        $display("FAIL frame dut1 @%0t: unexpected valid, outs %h", $time, {out3_b, out2_b, out1_b, out0_b});
      end else begin
        e = exp_qb.pop_front();
        if ({out3_b, out2_b, out1_b, out0_b} !== e) begin
          fails++;
          $display("FAIL frame dut1 @%0t: got %h expected %h", $time, {out3_b, out2_b, out1_b, out0_b}, e);
        end
      end
    end
  end

  initial begin
    int  ca, cb;
    bit  fa, fb;
    // reset for two cycles
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // dut_a directed: first frame 1,0,1,1 then 0,1,1,0 and 1,1,0,0
    a_frame(4'b1101, 4'b0001);
    a_frame(4'b0110, 4'b0001);
    a_frame(4'b0011, 4'b0001);
    // missing marker, a few idle HUNT cycles, relock
    a_frame(4'b1010, 4'b0000);
    a_frame(4'b0101, 4'b0001);
    // extra marker in slot 2, then full frames from the new alignment
    tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    a_frame(4'b1001, 4'b0001);
    a_frame(4'b1110, 4'b0001);

    // dut_b directed: A,5,F,3 then another frame, then reset inside slot 2
    b_frame(16'h3F5A, 4);
    b_frame(16'h9C41, 4);
    b_frame(16'h7777, 2);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 4'h8);
    b_frame(16'hE2B6, 4);
    b_frame(16'h1D08, 4);

    // randomized traffic with occasional missing/extra markers and resets
    ca = 0;
    cb = 0;
    for (int n = 0; n < 1500; n++) begin
      fa = (ca == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 40) == 0);
      fb = (cb == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 60) == 0);
      ca = fa ? 1 : (ca + 1) % 4;
      cb = fb ? 1 : (cb + 1) % 12;
      tick(($urandom_range(0, 300) == 0), fa, 1'($urandom), fb, 4'($urandom));
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    tests++;
    if (exp_qa.size() != 0) begin
      fails++;
      $display("FAIL drain dut0: %0d frames never published, expected 0", exp_qa.size());
    end
    tests++;
    if (exp_qb.size() != 0) begin
      fails++;
      $display("FAIL drain dut1: %0d frames never published, expected 0", exp_qb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart to the team's 4:1 channel multiplexer.
- Accepts a time-division-multiplexed serial stream carrying four channels in fixed slot order 0..3, with a frame marker on slot 0.
- Locks to the frame marker and tracks slot position with counters.
- Captures each slot into staging, then updates four parallel outputs together once per frame with a one-cycle valid pulse.

Parameters:
- WIDTH, 1, data width of the stream and of each output channel.
- SLOT_CYCLES, 1, clock cycles per slot (>=1).
- SAMPLE_POS, 0, cycle within a slot at which data is sampled (0..SLOT_CYCLES-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  TDM data stream.
- frame  input  1  high on the first cycle of slot 0.
- out0  output  WIDTH  channel 0, registered.
- out1  output  WIDTH  channel 1, registered.
- out2  output  WIDTH  channel 2, registered.
- out3  output  WIDTH  channel 3, registered.
- valid  output  1  one-cycle pulse; out0..out3 updated this cycle.
- sel1  output  1  current slot bit 1 (0 in HUNT).
- sel0  output  1  current slot bit 0 (0 in HUNT).
- locked  output  1  high in LOCKED.
- sync_err  output  1  one-cycle pulse on framing violation.

Behaviour:
- Reset (rst=1 at clk edge): state=HUNT; slot, cycle counter and staging cleared; out0..3=0; valid=0; sel1/sel0=0; locked=0; sync_err=0. Reset mid-frame discards partial staging; no valid is produced.
- Position: slot (2 bits) and cyc (0..SLOT_CYCLES-1) describe the current cycle.
  - In LOCKED, cyc increments each cycle and wraps at SLOT_CYCLES-1.
  - On each cyc wrap, slot increments, wrapping 3->0.
  - In HUNT, both counters are held at 0.
- HUNT:
  - frame=0: stay in HUNT.
  - frame=1: this cycle is slot0/cyc0; sample it if SAMPLE_POS=0; next state=LOCKED with position advanced.
- LOCKED, sampling: when cyc==SAMPLE_POS, stage[slot] <= in.
- LOCKED, frame publish: in the cycle with slot=3 and cyc=SAMPLE_POS:
  - on that edge, out0..2 <= stage[0..2] and out3 <= in;
  - valid=1 in the following cycle only.
  - Latency: slot-3 sample to valid = 1 cycle.
- LOCKED, framing checks:
  - Expected marker (slot0/cyc0, frame=1): normal operation.
  - Missing marker (slot0/cyc0, frame=0): sync_err pulse next cycle; state->HUNT; staging discarded.
  - Unexpected marker (frame=1 at any other position): sync_err pulse next cycle; resync with this cycle treated as slot0/cyc0; state stays LOCKED; staging for the aborted frame discarded.
- Simultaneous events: unexpected frame in the slot-3 sample cycle means resync wins; no output update and no valid.
- Hold: out0..3 hold their values between valid pulses and across HUNT.
- locked: registered copy of (state==LOCKED).
- sel1/sel0: registered copy of the slot counter in LOCKED; may drive the select inputs of the matching 4:1 multiplexer.

Test Plan:
- WIDTH=1, N=1, POS=0; rst 2 cycles, then frame with in=1,0,1,1 on consecutive cycles -> valid 1 cycle after the 4th sample; out0..3=1,0,1,1; locked=1; sync_err=0.
- Continuous frames with repeating patterns 0,1,1,0 then 1,1,0,0, frame every 4 cycles -> valid every 4 cycles; outputs track each frame; sel1/sel0 cycle 00,01,10,11.
- Frame missing at the second slot 0 -> sync_err one pulse; locked=0; no valid; out0..3 hold the previous frame's values.
- Extra frame at slot 2 -> sync_err pulse; next valid only after 4 full slots counted from the new frame; data taken from the new alignment.
- N=3, POS=1, WIDTH=4; slot values 0xA,0x5,0xF,0x3 each held 3 cycles -> out0..3=A,5,F,3; valid 1 cycle after slot-3 cycle 1.
- rst asserted during slot 2 -> next-cycle outputs all 0; state HUNT; no valid until a new full frame completes.
